riscv_str_issue_ctrl: RTL and testbench
=======================================

// Module: riscv_str_issue_ctrl
// PURPOSE
//  EX-stage initiator for the string-ops unit (STR_OP_UPPER/LOWER/LEET/ROT13). Takes one decoded
//  request, drives enable/operator/operand, waits for ready, captures the result, acks the unit,
//  presents a writeback. Handles WB backpressure, pipeline flush and a hung unit (timeout).
// PARAMETERS
//  TIMEOUT_CYCLES  32  max EXEC/DRAIN cycles waiting for str_ready_i; range 2..255
// PORTS
//  clk             in   1             core clock; all logic on posedge
//  rst             in   1             asynchronous, active-high reset
//  req_valid_i     in   1             request valid from ID/EX
//  req_op_i        in   STR_OP_WIDTH  string operator
//  req_operand_i   in   32            packed 4-char operand, byte 0 = first char
//  req_rd_i        in   5             destination register
//  req_ready_o     out  1             request accepted when valid & ready
//  flush_i         in   1             kill the in-flight request (no writeback)
//  str_en_o        out  1             enable to string unit
//  str_operator_o  out  STR_OP_WIDTH  captured operator
//  str_operand_o   out  32            captured operand
//  str_result_i    in   32            unit result; sampled only while str_en_o=1
//  str_ready_i     in   1             unit ready/done
//  str_ex_ready_o  out  1             one-cycle ack; returns the unit from FINISH to IDLE
//  wb_valid_o      out  1             writeback valid
//  wb_rd_o         out  5             writeback register
//  wb_data_o       out  32            writeback data
//  wb_err_o        out  1             1 = timeout; data is STR_RESULT_TIMEOUT
//  wb_ready_i      in   1             writeback consumer ready
//  busy_o          out  1             state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready_o=1; capture regs and counter cleared.
//  Reset mid-operation abandons everything with no writeback and no ack.
//  IDLE:  req_ready_o=1. valid&ready: capture op/operand/rd, cnt=0 -> EXEC.
//  EXEC:  str_en_o=1 with captured op/operand; cnt++ per cycle.
//   str_ready_i=1: wb_data<=str_result_i, wb_err<=0, str_ex_ready_o=1 this cycle -> WB.
//   Single-cycle ops take exactly 1 EXEC cycle: accept at t, result at t+1, wb_valid_o at t+2.
//   Count reaches TIMEOUT_CYCLES with no ready: wb_data<=32'hDEADBEEF, wb_err<=1, no ack -> WB.
//   flush_i (has priority over ready in the same cycle) -> DRAIN, cnt=0; result discarded.
//  DRAIN: str_en_o=0. Wait str_ready_i; pulse str_ex_ready_o for 1 cycle -> IDLE.
//   Timeout in DRAIN -> IDLE silently. flush_i ignored in DRAIN.
//  WB:    wb_valid_o=1; wb_rd/data/err held stable while !wb_ready_i.
//   flush_i -> IDLE; flush beats wb_ready_i in the same cycle, drops the writeback.
//   wb_ready_i: req_ready_o=1 in this cycle as well (back-to-back). If req_valid_i, capture
//   -> EXEC, else -> IDLE.
//  str_en_o deasserts in the cycle after the ack, so the unit never re-triggers LEET.
//  Counter is 8 bits, saturates, and never wraps.
// CONFIGURATION
//  STR_ISSUE_PERF_EN defined: adds perf_ops_o[31:0] and perf_cycles_o[31:0] outputs.
//   perf_ops_o counts completed writebacks (wb_valid & wb_ready & !flush).
//   perf_cycles_o counts EXEC cycles. Both wrap modulo 2^32 and reset to 0.
//  Macro undefined: these ports and counters do not exist. Core behaviour is identical.
// STRUCTURE
//  riscv_defines: str_issue_state_e {IDLE,EXEC,DRAIN,WB} and STR_RESULT_TIMEOUT=32'hDEADBEEF.
//  It also reuses STR_OP_WIDTH and STR_OP_*.
//  Sub-module riscv_str_issue_timer: clear/inc/saturating 8-bit counter with expired flag
//  at TIMEOUT_CYCLES.
// TESTING
//  UPPER, operand 0x64636261 ("abcd"), unit ready same cycle
//   -> wb_data 0x44434241, wb_err 0, wb_valid_o 2 cycles after accept.
//  LEET, operand 0x6C656574 ("teel"), unit ready 4 cycles after enable
//   -> wb_data 0x31333374, exactly one str_ex_ready_o pulse.
//  Unit model never ready, TIMEOUT_CYCLES=16 -> after 16 EXEC cycles:
//   wb_data 0xDEADBEEF, wb_err 1, str_ex_ready_o never pulses.
//  flush_i in 2nd EXEC cycle of LEET -> no wb_valid_o.
//   str_ex_ready_o pulses once when str_ready_i rises, then req_ready_o=1.
//  wb_ready_i low 5 cycles then high with a new UPPER request pending
//   -> WB outputs stable throughout, new request accepted on the release cycle.
//  rst asserted mid-EXEC -> next cycle all outputs 0, req_ready_o=1, no writeback.
//   With STR_ISSUE_PERF_EN: counters reset to 0.

Source files
------------

// File: rtl/riscv_str_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_str_issue_ctrl_pkg
// Shared definitions for the string-ops issue controller:
//   STR_OP_WIDTH / STR_OP_*   operator encoding of the string unit
//   STR_RESULT_TIMEOUT        writeback data reported when the unit hangs
//   str_issue_state_e         issue controller FSM states
// ---------------------------------------------------------------------------
package riscv_str_issue_ctrl_pkg;

    localparam int STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'd3;

    localparam logic [31:0] STR_RESULT_TIMEOUT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2,
        WB    = 2'd3
    } str_issue_state_e;

endpackage

// File: rtl/riscv_str_issue_ctrl_timer.sv
// ---------------------------------------------------------------------------
// riscv_str_issue_ctrl_timer
// Saturating 8-bit cycle counter used to bound how long the issue controller
// waits for the string unit.
//   clk, rst   clock / asynchronous active-high reset
//   clear      restart counting from 0 (wins over inc)
//   inc        count this cycle
//   expired    high during the TIMEOUT_CYCLES-th counted cycle (and after),
//              so the owner can leave on the edge that ends that cycle
// ---------------------------------------------------------------------------
module riscv_str_issue_ctrl_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (inc && (count_reg != 8'hFF)) begin
            // saturate instead of wrapping so a stuck owner never re-arms
            count_reg <= count_reg + 8'd1;
        end
    end

    // count holds the number of already-completed cycles, so the current
    // cycle is the last allowed one when count == TIMEOUT_CYCLES-1
    assign expired = (count_reg >= 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/riscv_str_issue_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_str_issue_ctrl
// EX-stage initiator for the string-ops unit. Accepts one decoded request,
// drives the unit, waits for ready (bounded by TIMEOUT_CYCLES), acks the
// unit and presents a writeback. Handles WB backpressure and flush.
//
// Ports
//   req_*          request handshake from ID/EX (req_ready_o accepts)
//   flush_i        kill in-flight request, no writeback
//   str_*          string unit interface (enable, operator, operand,
//                  result, ready, one-cycle ack str_ex_ready_o)
//   wb_*           writeback (valid/ready, rd, data, err=timeout)
//   busy_o         controller not idle
//
// Optional build macro STR_ISSUE_PERF_EN adds perf_ops_o (completed
// writebacks) and perf_cycles_o (EXEC cycles), both 32-bit wrapping.
// ---------------------------------------------------------------------------
module riscv_str_issue_ctrl
    import riscv_str_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic [STR_OP_WIDTH-1:0] req_op_i,
    input  logic [31:0]             req_operand_i,
    input  logic [4:0]              req_rd_i,
    output logic                    req_ready_o,
    input  logic                    flush_i,
    output logic                    str_en_o,
    output logic [STR_OP_WIDTH-1:0] str_operator_o,
    output logic [31:0]             str_operand_o,
    input  logic [31:0]             str_result_i,
    input  logic                    str_ready_i,
    output logic                    str_ex_ready_o,
    output logic                    wb_valid_o,
    output logic [4:0]              wb_rd_o,
    output logic [31:0]             wb_data_o,
    output logic                    wb_err_o,
    input  logic                    wb_ready_i,
    output logic                    busy_o
`ifdef STR_ISSUE_PERF_EN
    ,
    output logic [31:0]             perf_ops_o,
    output logic [31:0]             perf_cycles_o
`endif
);

    str_issue_state_e        state_reg;
    logic [STR_OP_WIDTH-1:0] op_reg;
    logic [31:0]             operand_reg;
    logic [4:0]              rd_reg;
    logic [31:0]             wb_data_reg;
    logic                    wb_err_reg;

    logic accept;
    logic timer_clear;
    logic timer_inc;
    logic expired;

    // WB hands back req_ready in the release cycle for back-to-back issue;
    // a flush in that cycle drops the writeback and blocks the new accept.
    assign req_ready_o = (state_reg == IDLE) ||
                         ((state_reg == WB) && wb_ready_i && !flush_i);
    assign accept      = req_valid_i && req_ready_o;

    assign str_en_o       = (state_reg == EXEC);
    assign str_operator_o = op_reg;
    assign str_operand_o  = operand_reg;
    assign wb_valid_o     = (state_reg == WB);
    assign wb_rd_o        = rd_reg;
    assign wb_data_o      = wb_data_reg;
    assign wb_err_o       = wb_err_reg;
    assign busy_o         = (state_reg != IDLE);

    // Ack the unit in the same cycle it reports ready. In EXEC a flush
    // takes priority, and the ack is then given later from DRAIN.
    assign str_ex_ready_o = str_ready_i &&
                            (((state_reg == EXEC) && !flush_i) || (state_reg == DRAIN));

    // Counter restarts on every entry into EXEC or DRAIN
    assign timer_clear = accept || ((state_reg == EXEC) && flush_i);
    assign timer_inc   = (state_reg == EXEC) || (state_reg == DRAIN);

    riscv_str_issue_ctrl_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            operand_reg <= '0;
            rd_reg      <= '0;
            wb_data_reg <= '0;
            wb_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg      <= req_op_i;
                        operand_reg <= req_operand_i;
                        rd_reg      <= req_rd_i;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush_i) begin
                        state_reg <= DRAIN;
                    end else if (str_ready_i) begin
                        wb_data_reg <= str_result_i;
                        wb_err_reg  <= 1'b0;
                        state_reg   <= WB;
                    end else if (expired) begin
                        wb_data_reg <= STR_RESULT_TIMEOUT;
                        wb_err_reg  <= 1'b1;
                        state_reg   <= WB;
                    end
                end
                DRAIN: begin
                    // a hung unit is abandoned silently
                    if (str_ready_i || expired) begin
                        state_reg <= IDLE;
                    end
                end
                WB: begin
                    if (flush_i) begin
                        state_reg <= IDLE;
                    end else if (wb_ready_i) begin
                        if (accept) begin
                            op_reg      <= req_op_i;
                            operand_reg <= req_operand_i;
                            rd_reg      <= req_rd_i;
                            state_reg   <= EXEC;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef STR_ISSUE_PERF_EN
    logic [31:0] perf_ops_reg;
    logic [31:0] perf_cycles_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_reg    <= 32'd0;
            perf_cycles_reg <= 32'd0;
        end else begin
            if ((state_reg == WB) && wb_ready_i && !flush_i) begin
                perf_ops_reg <= perf_ops_reg + 32'd1;
            end
            if (state_reg == EXEC) begin
                perf_cycles_reg <= perf_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_ops_o    = perf_ops_reg;
    assign perf_cycles_o = perf_cycles_reg;
`endif

endmodule

// File: tb/tb_riscv_str_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_str_issue_ctrl
// Self-checking bench for riscv_str_issue_ctrl (TIMEOUT_CYCLES=16) with a
// behavioural string unit whose ready latency is programmable per request.
// ---------------------------------------------------------------------------
module tb_riscv_str_issue_ctrl;
    import riscv_str_issue_ctrl_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  rd;
        int          delay;      // -1 = unit never ready
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_en;     // EXEC cycles
        int          exp_acks;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [1:0]  req_op_i = '0;
    logic [31:0] req_operand_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        req_ready_o;
    logic        flush_i = 1'b0;
    logic        str_en_o;
    logic [1:0]  str_operator_o;
    logic [31:0] str_operand_o;
    logic [31:0] str_result_i;
    logic        str_ready_i;
    logic        str_ex_ready_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_err_o;
    logic        wb_ready_i = 1'b1;
    logic        busy_o;
`ifdef STR_ISSUE_PERF_EN
    logic [31:0] perf_ops_o;
    logic [31:0] perf_cycles_o;
`endif

    always #5 clk = ~clk;

    riscv_str_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_op_i       (req_op_i),
        .req_operand_i  (req_operand_i),
        .req_rd_i       (req_rd_i),
        .req_ready_o    (req_ready_o),
        .flush_i        (flush_i),
        .str_en_o       (str_en_o),
        .str_operator_o (str_operator_o),
        .str_operand_o  (str_operand_o),
        .str_result_i   (str_result_i),
        .str_ready_i    (str_ready_i),
        .str_ex_ready_o (str_ex_ready_o),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .wb_err_o       (wb_err_o),
        .wb_ready_i     (wb_ready_i),
        .busy_o         (busy_o)
`ifdef STR_ISSUE_PERF_EN
        ,
        .perf_ops_o     (perf_ops_o),
        .perf_cycles_o  (perf_cycles_o)
`endif
    );

    // ---------------- string unit model ----------------
    function automatic logic [7:0] char_fn(input logic [1:0] op, input logic [7:0] c);
        logic [7:0] r;
        r = c;
        case (op)
            STR_OP_UPPER: if (c >= 8'h61 && c <= 8'h7A) r = c - 8'h20;
            STR_OP_LOWER: if (c >= 8'h41 && c <= 8'h5A) r = c + 8'h20;
            STR_OP_ROT13: begin
                if (c >= 8'h61 && c <= 8'h7A) r = 8'h61 + 8'((c - 8'h61 + 8'd13) % 8'd26);
                else if (c >= 8'h41 && c <= 8'h5A) r = 8'h41 + 8'((c - 8'h41 + 8'd13) % 8'd26);
            end
            default: begin
                case (c)
                    8'h61: r = 8'h34;  // a -> 4
                    8'h65: r = 8'h33;  // e -> 3
                    8'h69: r = 8'h31;  // i -> 1
                    8'h6C: r = 8'h31;  // l -> 1
                    8'h6F: r = 8'h30;  // o -> 0
                    8'h73: r = 8'h35;  // s -> 5
                    default: r = c;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] unit_fn(input logic [1:0] op, input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = char_fn(op, w[b*8 +: 8]);
        return r;
    endfunction

    int   unit_delay = 0;
    logic unit_active = 1'b0;
    int   unit_cnt = 0;
    logic unit_abort = 1'b0;

    always @(posedge clk) begin
        if (unit_abort) begin
            unit_active <= 1'b0;
            unit_cnt    <= 0;
        end else if (unit_active && str_ex_ready_o) begin
            unit_active <= 1'b0;
            unit_cnt    <= 0;
        end else if (unit_active) begin
            unit_cnt <= unit_cnt + 1;
        end else if (str_en_o && !str_ex_ready_o) begin
            unit_active <= 1'b1;
            unit_cnt    <= 1;
        end
    end

    assign str_ready_i  = (unit_active || str_en_o) && (unit_delay >= 0) &&
                          ((unit_active ? unit_cnt : 0) >= unit_delay);
    assign str_result_i = str_en_o ? unit_fn(str_operator_o, str_operand_o) : 32'h0;

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    exp_t sb_q[$];
    exp_t next_exp;
    logic push_en = 1'b0;
    int   cyc = 0, acc_cyc = 0, wb_cyc = 0;
    int   ack_count = 0, en_count = 0, wbv_count = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (str_ex_ready_o) ack_count++;
            if (str_en_o) en_count++;
            if (wb_valid_o) wbv_count++;
            if (req_valid_i && req_ready_o) begin
                acc_cyc = cyc;
                if (push_en) sb_q.push_back(next_exp);
            end
            if (wb_valid_o && wb_ready_i && !flush_i) begin
                wb_cyc = cyc;
                $display("[TB] wb rd=%0d data=0x%08h err=%0d", wb_rd_o, wb_data_o, wb_err_o);
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wb: got rd=%0d data=0x%08h, required no writeback",
                             wb_rd_o, wb_data_o);
                end else begin
                    e = sb_q.pop_front();
                    check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                    check("wb_data", 64'(wb_data_o), 64'(e.data));
                    check("wb_err", 64'(wb_err_o), 64'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] operand, input logic [4:0] rd,
                         input int delay, input logic [31:0] exp_data, input logic exp_err,
                         input logic push);
        logic acc;
        acc = 1'b0;
        @(posedge clk); #1;
        unit_delay    = delay;
        next_exp      = '{rd: rd, data: exp_data, err: exp_err};
        push_en       = push;
        req_op_i      = op;
        req_operand_i = operand;
        req_rd_i      = rd;
        req_valid_i   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        check("req_accept", 64'(acc), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                idle = 1'b1;
                break;
            end
        end
        check(name, 64'(idle), 64'd1);
    endtask

    task automatic kick_unit();
        @(posedge clk); #1 unit_abort = 1'b1;
        @(posedge clk); #1 unit_abort = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{STR_OP_UPPER, 32'h64636261, 5'd1, 0,  32'h44434241, 1'b0, 1,  1};
        vecs[1] = '{STR_OP_LOWER, 32'h44434241, 5'd2, 2,  32'h64636261, 1'b0, 3,  1};
        vecs[2] = '{STR_OP_ROT13, 32'h64636261, 5'd3, 1,  32'h71706F6E, 1'b0, 2,  1};
        vecs[3] = '{STR_OP_LEET,  32'h6C656574, 5'd4, 4,  32'h31333374, 1'b0, 5,  1};
        vecs[4] = '{STR_OP_UPPER, 32'h64636261, 5'd5, -1, 32'hDEADBEEF, 1'b1, TO, 0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({req_ready_o, str_en_o, str_ex_ready_o, wb_valid_o, wb_err_o, busy_o}),
              64'b100000);
        check("reset_data", 64'({wb_rd_o, wb_data_o, str_operator_o, str_operand_o[15:0]}), 64'd0);
        #1 rst = 1'b0;

        // ---- table-driven single transactions ----
        foreach (vecs[k]) begin
            ack_count = 0;
            en_count  = 0;
            issue(vecs[k].op, vecs[k].operand, vecs[k].rd, vecs[k].delay,
                  vecs[k].exp_data, vecs[k].exp_err, 1'b1);
            wait_idle("vec_idle");
            @(negedge clk); #1;
            $display("[TB] vec %0d op=%0d acks=%0d exec=%0d lat=%0d", k, vecs[k].op,
                     ack_count, en_count, wb_cyc - acc_cyc);
            check("vec_acks", 64'(ack_count), 64'(vecs[k].exp_acks));
            check("vec_exec_cycles", 64'(en_count), 64'(vecs[k].exp_en));
            check("vec_wb_latency", 64'(wb_cyc - acc_cyc), 64'(vecs[k].exp_en + 1));
            check("vec_sb_empty", 64'(sb_q.size()), 64'd0);
            if (vecs[k].delay < 0) kick_unit();
        end

`ifdef STR_ISSUE_PERF_EN
        check("perf_ops", 64'(perf_ops_o), 64'd5);
        check("perf_cycles", 64'(perf_cycles_o), 64'd27);
`endif

        // ---- flush in 2nd EXEC cycle of LEET ----
        ack_count = 0;
        wbv_count = 0;
        issue(STR_OP_LEET, 32'h6C656574, 5'd6, 4, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (str_ex_ready_o) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("flush_ack_seen", 64'(seen), 64'd1);
        end
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready_o), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        $display("[TB] flush acks=%0d wb_valid_cycles=%0d", ack_count, wbv_count);
        check("flush_one_ack", 64'(ack_count), 64'd1);
        check("flush_no_wb", 64'(wbv_count), 64'd0);

        // ---- WB backpressure with back-to-back request ----
        wb_ready_i = 1'b0;
        ack_count  = 0;
        issue(STR_OP_UPPER, 32'h64636261, 5'd7, 0, 32'h44434241, 1'b0, 1'b1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (wb_valid_o) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("bp_wb_seen", 64'(seen), 64'd1);
        end
        @(posedge clk); #1;
        next_exp      = '{rd: 5'd9, data: 32'h41424344, err: 1'b0};
        req_op_i      = STR_OP_UPPER;
        req_operand_i = 32'h61626364;
        req_rd_i      = 5'd9;
        req_valid_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({req_ready_o, wb_valid_o, wb_err_o, wb_rd_o, wb_data_o}),
                  {25'd0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h44434241});
            @(posedge clk); #1;
        end
        wb_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_accept", 64'({req_ready_o, wb_valid_o}), 64'b11);
        @(posedge clk); #1 req_valid_i = 1'b0;
        wait_idle("bp_idle");
        @(negedge clk); #1;
        check("bp_acks", 64'(ack_count), 64'd2);
        check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // ---- reset mid-EXEC ----
        ack_count = 0;
        issue(STR_OP_LEET, 32'h6C656574, 5'd8, -1, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        unit_abort = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", 64'({req_ready_o, str_en_o, str_ex_ready_o, wb_valid_o, wb_err_o, busy_o}),
              64'b100000);
        check("rst_mid_data", 64'({wb_rd_o, wb_data_o}), 64'd0);
        check("rst_mid_str", 64'({str_operator_o, str_operand_o}), 64'd0);
`ifdef STR_ISSUE_PERF_EN
        check("rst_mid_perf", {perf_ops_o, perf_cycles_o}, 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        unit_abort = 1'b0;
        wbv_count = 0;
        repeat (20) @(negedge clk);
        #1;
        check("rst_no_wb", 64'(wbv_count), 64'd0);
        check("rst_no_ack", 64'(ack_count), 64'd0);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
